gray_counter: RTL
=================

Name: gray_counter

Overview:
- Synchronous up/down counter whose registered output is 4-bit-style reflected Gray code, parameterised in width.
- Sits directly upstream of the gray2bin converter; gray_out feeds its input.
- Keeps a binary shadow count (bin_out) so the bench can compare converter output against the true count every cycle.
- Gray output is fully registered, so exactly one bit toggles per count step and there are no decode glitches.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end values.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clk edge while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_bin  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray code of the current count.
- bin_out  output  WIDTH  registered binary count.
- tc  output  1  terminal-count flag, registered.

Behaviour:
- Reset: async assert while rst_n=0, effective immediately with no clock needed.
  - bin_out=0, gray_out=0, tc=0.
  - Release is synchronous to clk; the first count happens on the first rising edge with rst_n=1.
- Invariant: every cycle, gray_out == bin_out ^ (bin_out >> 1). Both registers update on the same edge.
- Per-edge priority: load > en > hold.
  - load=1: bin_out<=load_bin; gray_out<=load_bin^(load_bin>>1); tc<=0. en and up_dn are ignored.
  - en=1, up_dn=1, not at max (all-ones): bin_out<=bin_out+1.
  - en=1, up_dn=0, not at min (0): bin_out<=bin_out-1.
  - en=0: hold all registers; tc<=0.
- Boundary, WRAP=1:
  - Up from all-ones -> 0.
  - Down from 0 -> all-ones.
  - tc=1 for exactly the one cycle after the wrapping edge, concurrent with the new value. Otherwise tc<=0.
- Boundary, WRAP=0:
  - An up step at all-ones, or a down step at 0, is blocked; the count holds.
  - tc=1 in every cycle following a blocked step.
  - tc falls to 0 on the first edge that performs a legal step, a load, or en=0.
- Direction change mid-count takes effect on the same edge; there is no pipeline.
  - Example: up to 5, then down, gives 4 on the next edge.
- Latency: one clk from en/load sampling to the new outputs.
- Single-bit property: on every count step (not load, not reset), popcount(gray_out_new ^ gray_out_old) == 1. This includes wrap steps.
- Reset mid-operation: outputs go to 0 asynchronously. No pending load or tc survives reset.
- Arithmetic is WIDTH-bit unsigned; no carry output beyond tc.

Test Plan (WIDTH=4):
- Reset/count-up
  - Stimulus: rst_n=0, then release; en=1, up_dn=1 for 16 edges.
  - Response: gray_out = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - tc=1 only in the 0000 cycle after 1000.
  - The downstream gray2bin output equals bin_out every cycle.
- Count-down wrap
  - Stimulus: from 0, en=1, up_dn=0, one edge.
  - Response: bin_out=1111, gray_out=1000, tc=1. Next edge: bin_out=1110, gray_out=1001, tc=0.
- Load priority
  - Stimulus: load=1, load_bin=1010, en=1, up_dn=1.
  - Response: bin_out=1010, gray_out=1111, tc=0. The increment is ignored.
- Saturate (WRAP=0)
  - Stimulus: load 1111, then en=1, up_dn=1 for 3 edges.
  - Response: bin_out stays 1111, gray_out stays 1000, tc=1 for all 3 cycles.
  - Then up_dn=0, one edge: bin_out=1110, tc=0.
- Async reset mid-count
  - Stimulus: counting at bin 0110; drop rst_n between clock edges.
  - Response: gray_out=0000, bin_out=0000, tc=0 before the next edge. They hold through the reset, then resume counting from 0.
- Exhaustive single-bit check
  - Stimulus: 200 random en/up_dn cycles, no load.
  - Response: every count step changes exactly one gray_out bit; gray_out == bin_out^(bin_out>>1) always.

Source files
------------

// File: rtl/gray_counter_if.sv
// Control/status bundle between a gray_counter and whatever drives it.
// The master drives the count controls and observes the registered outputs.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             tc;

  modport master (
    output en, up_dn, load, load_bin,
    input  gray_out, bin_out, tc
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output gray_out, bin_out, tc
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter with a registered reflected-Gray output and a binary shadow
// count. WRAP selects modulo wrap-around or saturation at the end values.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             tc_q;
  logic             tc_d;

  logic at_max;
  logic at_min;
  logic step_up;
  logic step_dn;
  logic edge_hit;

  assign at_max   = (bin_q == CNT_MAX);
  assign at_min   = (bin_q == CNT_MIN);
  assign step_up  = !bus.load && bus.en &&  bus.up_dn;
  assign step_dn  = !bus.load && bus.en && !bus.up_dn;
  // An attempted step past either end: wraps when WRAP=1, is blocked otherwise.
  assign edge_hit = (step_up && at_max) || (step_dn && at_min);

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bin_d = bus.load_bin;
    end else if (edge_hit) begin
      tc_d = 1'b1;
      if (WRAP) begin
        bin_d = step_up ? CNT_MIN : CNT_MAX;
      end
    end else if (step_up) begin
      bin_d = bin_q + CNT_ONE;
    end else if (step_dn) begin
      bin_d = bin_q - CNT_ONE;
    end
  end

  // Gray is derived from the next binary value so both registers load on the
  // same edge and the output never passes through a decoded intermediate.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= CNT_MIN;
      gray_q <= CNT_MIN;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule
